// File: rtl/alu_seq.sv
// Sequential MIPS-style ALU: single-cycle logic/arith ops plus W-cycle iterative
// multiply and divide, with a valid/ready handshake on both sides.
module alu_seq #(
  parameter int W    = 32,
  parameter int W_OP = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W_OP-1:0] alu_op,
  input  logic [W-1:0]    A,
  input  logic [W-1:0]    B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    R,
  output logic [W-1:0]    hi,
  output logic [W-1:0]    lo,
  output logic            overflow,
  output logic            is_zero,
  output logic            div0,
  output logic            bad_op
);

  localparam int SW = $clog2(W);
  localparam logic [SW-1:0] LAST = SW'(W - 1);
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  localparam logic [W_OP-1:0] OP_SLL   = W_OP'(6'h00);
  localparam logic [W_OP-1:0] OP_SRL   = W_OP'(6'h02);
  localparam logic [W_OP-1:0] OP_SRA   = W_OP'(6'h03);
  localparam logic [W_OP-1:0] OP_MULT  = W_OP'(6'h18);
  localparam logic [W_OP-1:0] OP_MULTU = W_OP'(6'h19);
  localparam logic [W_OP-1:0] OP_DIV   = W_OP'(6'h1A);
  localparam logic [W_OP-1:0] OP_DIVU  = W_OP'(6'h1B);
  localparam logic [W_OP-1:0] OP_ADD   = W_OP'(6'h20);
  localparam logic [W_OP-1:0] OP_ADDU  = W_OP'(6'h21);
  localparam logic [W_OP-1:0] OP_SUB   = W_OP'(6'h22);
  localparam logic [W_OP-1:0] OP_SUBU  = W_OP'(6'h23);
  localparam logic [W_OP-1:0] OP_AND   = W_OP'(6'h24);
  localparam logic [W_OP-1:0] OP_OR    = W_OP'(6'h25);
  localparam logic [W_OP-1:0] OP_XOR   = W_OP'(6'h26);
  localparam logic [W_OP-1:0] OP_NOR   = W_OP'(6'h27);
  localparam logic [W_OP-1:0] OP_SLT   = W_OP'(6'h2A);
  localparam logic [W_OP-1:0] OP_SLTU  = W_OP'(6'h2B);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [W_OP-1:0] op_q, op_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [W-1:0]    acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic            neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic [W-1:0]    r_q, r_d, hi_q, hi_d, lo_q, lo_d;
  logic            ovf_q, ovf_d, zero_q, zero_d, div0_q, div0_d, bad_q, bad_d;

  logic            transfer, in_multi, in_mul, in_sgn, op_mul, op_sgn;
  logic [W-1:0]    sum, diff, r1, a_mag, b_mag;
  logic [SW-1:0]   shamt;
  logic            ovf1, bad1;
  logic [W:0]      mul_sum, div_sh;
  logic [W-1:0]    mul_hi, mul_lo, div_sub, div_hi, div_lo, quot_f, rem_f;
  logic            div_ge;
  logic [2*W-1:0]  prod_f;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign transfer  = in_valid && in_ready;
  assign R         = r_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign overflow  = ovf_q;
  assign is_zero   = zero_q;
  assign div0      = div0_q;
  assign bad_op    = bad_q;

  assign in_mul   = (alu_op == OP_MULT) || (alu_op == OP_MULTU);
  assign in_multi = in_mul || (alu_op == OP_DIV) || (alu_op == OP_DIVU);
  assign in_sgn   = (alu_op == OP_MULT) || (alu_op == OP_DIV);
  assign a_mag    = (in_sgn && A[W-1]) ? -A : A;
  assign b_mag    = (in_sgn && B[W-1]) ? -B : B;
  assign op_mul   = (op_q == OP_MULT) || (op_q == OP_MULTU);
  assign op_sgn   = (op_q == OP_MULT) || (op_q == OP_DIV);

  always_comb begin
    sum   = A + B;
    diff  = A - B;
    shamt = B[SW-1:0];
    r1    = '0;
    ovf1  = 1'b0;
    bad1  = 1'b0;
    case (alu_op)
      OP_ADD:  begin
        r1   = sum;
        ovf1 = (A[W-1] == B[W-1]) && (sum[W-1] != A[W-1]);
      end
      OP_ADDU: r1 = sum;
      OP_SUB:  begin
        r1   = diff;
        ovf1 = (A[W-1] != B[W-1]) && (diff[W-1] != A[W-1]);
      end
      OP_SUBU: r1 = diff;
      OP_AND:  r1 = A & B;
      OP_OR:   r1 = A | B;
      OP_XOR:  r1 = A ^ B;
      OP_NOR:  r1 = ~(A | B);
      OP_SLT:  r1 = {{(W-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: r1 = {{(W-1){1'b0}}, (A < B)};
      OP_SLL:  r1 = A << shamt;
      OP_SRL:  r1 = A >> shamt;
      OP_SRA:  r1 = $unsigned($signed(A) >>> shamt);
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: r1 = '0;
      default: bad1 = 1'b1;
    endcase
  end

  // One shift-add or restoring-subtract step on magnitudes; signs are fixed at the end.
  always_comb begin
    mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    mul_hi  = mul_sum[W:1];
    mul_lo  = {mul_sum[0], acc_lo_q[W-1:1]};
    div_sh  = {acc_hi_q, acc_lo_q[W-1]};
    div_ge  = div_sh >= {1'b0, opnd_q};
    div_sub = div_sh[W-1:0] - opnd_q;
    div_hi  = div_ge ? div_sub : div_sh[W-1:0];
    div_lo  = {acc_lo_q[W-2:0], div_ge};
    prod_f  = neg_lo_q ? -{mul_hi, mul_lo} : {mul_hi, mul_lo};
    quot_f  = neg_lo_q ? -div_lo : div_lo;
    rem_f   = neg_hi_q ? -div_hi : div_hi;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    r_d      = r_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    div0_d   = div0_q;
    bad_d    = bad_q;
    case (state_q)
      IDLE, DONE: begin
        if (transfer) begin
          op_d = alu_op;
          a_d  = A;
          b_d  = B;
          if (in_multi) begin
            state_d  = BUSY;
            cnt_d    = '0;
            acc_hi_d = '0;
            acc_lo_d = in_mul ? b_mag : a_mag;
            opnd_d   = in_mul ? a_mag : b_mag;
            neg_lo_d = in_sgn && (A[W-1] ^ B[W-1]);
            neg_hi_d = in_sgn && A[W-1];
          end else begin
            state_d = DONE;
            r_d     = r1;
            hi_d    = '0;
            lo_d    = '0;
            ovf_d   = ovf1;
            zero_d  = (r1 == '0);
            div0_d  = 1'b0;
            bad_d   = bad1;
          end
        end else if (state_q == DONE && out_ready) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        cnt_d    = cnt_q + SW'(1);
        acc_hi_d = op_mul ? mul_hi : div_hi;
        acc_lo_d = op_mul ? mul_lo : div_lo;
        if (cnt_q == LAST) begin
          state_d = DONE;
          bad_d   = 1'b0;
          if (op_mul) begin
            hi_d   = prod_f[2*W-1:W];
            lo_d   = prod_f[W-1:0];
            ovf_d  = 1'b0;
            div0_d = 1'b0;
          end else if (opnd_q == '0) begin
            hi_d   = a_q;
            lo_d   = '1;
            ovf_d  = 1'b0;
            div0_d = 1'b1;
          end else begin
            hi_d   = rem_f;
            lo_d   = quot_f;
            ovf_d  = op_sgn && (a_q == MIN_NEG) && (b_q == '1);
            div0_d = 1'b0;
          end
          r_d    = lo_d;
          zero_d = (lo_d == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      r_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      div0_q   <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      r_q      <= r_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      div0_q   <= div0_d;
      bad_q    <= bad_d;
    end
  end

endmodule
